// File: rtl/alu_muldiv_sequencer_pkg.sv
// Shared encodings for the multi-cycle MUL/DIVU/REMU sequencer:
// operation codes, FSM states and the shared-ALU control values.
package alu_muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

endpackage

// File: rtl/alu_muldiv_sequencer_if.sv
// Execute-stage request/result bundle plus the borrowed shared-ALU operand path.
// master = pipeline side (including the external ALU), slave = sequencer.
interface alu_muldiv_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  StartE;
    logic [1:0]            OpE;
    logic [DATA_WIDTH-1:0] RD1E;
    logic [DATA_WIDTH-1:0] RD2E;
    logic                  FlushE;
    logic [DATA_WIDTH-1:0] AluOut;
    logic                  AluOwn;
    logic [DATA_WIDTH-1:0] AluSrcA;
    logic [DATA_WIDTH-1:0] AluSrcB;
    logic [2:0]            AluCtrl;
    logic                  StallMD;
    logic                  DoneMD;
    logic [DATA_WIDTH-1:0] ResultMD;

    modport master (
        output StartE, OpE, RD1E, RD2E, FlushE, AluOut,
        input  AluOwn, AluSrcA, AluSrcB, AluCtrl, StallMD, DoneMD, ResultMD
    );

    modport slave (
        input  StartE, OpE, RD1E, RD2E, FlushE, AluOut,
        output AluOwn, AluSrcA, AluSrcB, AluCtrl, StallMD, DoneMD, ResultMD
    );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Iterative shift-add multiplier and restoring divider that borrow the shared
// Execute-stage ALU for one add/subtract per cycle, stalling the front end meanwhile.
module alu_muldiv_sequencer
    import alu_muldiv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    alu_muldiv_sequencer_if.slave        bus
);

    state_e                r_state;
    state_e                w_next_state;
    op_e                   r_op;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_divisor;

    op_e                   w_op;
    logic                  w_start_ok;
    logic                  w_accept;
    logic                  w_div_zero;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_rem_shift;
    logic                  w_div_take;

    assign w_op        = op_e'(bus.OpE);
    assign w_start_ok  = bus.StartE && (w_op != OP_RSVD);
    assign w_accept    = w_start_ok && !bus.FlushE;
    assign w_div_zero  = (bus.RD2E == '0);
    assign w_last      = (r_count == CNT_WIDTH'(DATA_WIDTH - 1));
    assign w_rem_shift = {r_rem[DATA_WIDTH-2:0], r_quo[DATA_WIDTH-1]};
    // A set rem MSB means the true 33-bit partial remainder already exceeds the divisor.
    assign w_div_take  = r_rem[DATA_WIDTH-1] || (w_rem_shift >= r_divisor);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_op == OP_MUL) begin
                        w_next_state = S_MUL;
                    end else if (w_div_zero) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (bus.FlushE) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_MUL;
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_count <= '0;
                        if (w_op == OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= bus.RD1E;
                            r_mplier <= bus.RD2E;
                        end else if (w_div_zero) begin
                            r_quo <= '1;
                            r_rem <= bus.RD1E;
                        end else begin
                            r_rem     <= '0;
                            r_quo     <= bus.RD1E;
                            r_divisor <= bus.RD2E;
                        end
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_acc <= bus.AluOut;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_WIDTH'(1);
                end
                S_DIV: begin
                    if (w_div_take) begin
                        r_rem <= bus.AluOut;
                        r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_shift;
                        r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b0};
                    end
                    r_count <= r_count + CNT_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.AluOwn   = 1'b0;
        bus.AluSrcA  = '0;
        bus.AluSrcB  = '0;
        bus.AluCtrl  = ALU_ADD;
        bus.StallMD  = 1'b0;
        bus.DoneMD   = 1'b0;
        bus.ResultMD = '0;
        case (r_state)
            S_IDLE: bus.StallMD = w_start_ok;
            S_MUL: begin
                bus.AluOwn  = 1'b1;
                bus.AluSrcA = r_acc;
                bus.AluSrcB = r_mcand;
                bus.AluCtrl = ALU_ADD;
                bus.StallMD = 1'b1;
            end
            S_DIV: begin
                bus.AluOwn  = 1'b1;
                bus.AluSrcA = w_rem_shift;
                bus.AluSrcB = r_divisor;
                bus.AluCtrl = ALU_SUB;
                bus.StallMD = 1'b1;
            end
            S_DONE: begin
                // A flush landing on the DONE cycle kills the result strobe.
                if (!bus.FlushE) begin
                    bus.DoneMD = 1'b1;
                    case (r_op)
                        OP_MUL:  bus.ResultMD = r_acc;
                        OP_DIVU: bus.ResultMD = r_quo;
                        OP_REMU: bus.ResultMD = r_rem;
                        default: bus.ResultMD = '0;
                    endcase
                end
            end
            default: begin
            end
        endcase
        if (rst) begin
            bus.AluOwn   = 1'b0;
            bus.AluSrcA  = '0;
            bus.AluSrcB  = '0;
            bus.AluCtrl  = ALU_ADD;
            bus.StallMD  = 1'b0;
            bus.DoneMD   = 1'b0;
            bus.ResultMD = '0;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// random operations compared against plain-arithmetic expected results.
module tb_alu_muldiv_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_muldiv_sequencer_if #(.DATA_WIDTH(32)) bus ();

    alu_muldiv_sequencer #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External shared ALU
    assign bus.AluOut = (bus.AluCtrl == 3'b001) ? (bus.AluSrcA - bus.AluSrcB)
                                                : (bus.AluSrcA + bus.AluSrcB);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_ctl"}, {58'd0, bus.AluOwn, bus.AluCtrl, bus.StallMD, bus.DoneMD}, 64'd0);
        check({nm, "_dat"}, {32'd0, bus.AluSrcA | bus.AluSrcB | bus.ResultMD}, 64'd0);
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'b00: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic wait_no_done(input string nm, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (bus.DoneMD) seen = 1'b1;
            tick();
        end
        check(nm, {63'd0, seen}, 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls,
                          output bit strobe_ok, output bit zero_ok);
        bit done;
        bus.StartE = 1'b1;
        bus.OpE    = op;
        bus.RD1E   = a;
        bus.RD2E   = b;
        #1;
        stalls  = bus.StallMD ? 1 : 0;
        res     = '0;
        lat     = -1;
        zero_ok = 1'b1;
        done    = 1'b0;
        tick();
        bus.StartE = 1'b0;
        #1;
        for (int c = 1; c <= 100 && !done; c++) begin
            if (bus.StallMD) stalls++;
            if (bus.DoneMD) begin
                res  = bus.ResultMD;
                lat  = c;
                done = 1'b1;
            end else begin
                if (bus.ResultMD != 0) zero_ok = 1'b0;
                tick();
            end
        end
        tick();
        strobe_ok = !bus.DoneMD;
    endtask

    task automatic op_and_check(input string nm, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_res,
                                input int exp_lat);
        logic [31:0] res;
        int          lat;
        int          stalls;
        bit          strobe_ok;
        bit          zero_ok;
        run_op(op, a, b, res, lat, stalls, strobe_ok, zero_ok);
        check({nm, "_result"}, {32'd0, res}, {32'd0, exp_res});
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
        check({nm, "_strobe_one_cycle"}, {63'd0, strobe_ok}, 64'd1);
        check({nm, "_result_zero_idle"}, {63'd0, zero_ok}, 64'd1);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        bit          done;

        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.StartE  = 1'b0;
        bus.OpE     = 2'b00;
        bus.RD1E    = '0;
        bus.RD2E    = '0;
        bus.FlushE  = 1'b0;

        vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         33};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33};
        vecs[2]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
        vecs[3]  = '{2'b10, 32'd100,        32'd7,          32'd2,          33};
        vecs[4]  = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          33};
        vecs[5]  = '{2'b10, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  33};
        vecs[6]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[7]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
        vecs[8]  = '{2'b00, 32'h1234_5678,  32'd0,          32'd0,          33};
        vecs[9]  = '{2'b01, 32'd3,          32'd10,         32'd0,          33};
        vecs[10] = '{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[11] = '{2'b01, 32'h8000_0000,  32'd1,          32'h8000_0000,  33};

        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_quiet("reset_state");

        for (int i = 0; i < 12; i++) begin
            op_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                         vecs[i].exp_res, vecs[i].exp_lat);
        end

        // Reserved op is ignored
        bus.StartE = 1'b1;
        bus.OpE    = 2'b11;
        bus.RD1E   = 32'd9;
        bus.RD2E   = 32'd9;
        #1;
        check("rsvd_stall", {63'd0, bus.StallMD}, 64'd0);
        tick();
        bus.StartE = 1'b0;
        #1;
        check("rsvd_not_started", {63'd0, bus.AluOwn}, 64'd0);
        wait_no_done("rsvd_no_done", 40);

        // FlushE beats StartE in IDLE
        bus.StartE = 1'b1;
        bus.FlushE = 1'b1;
        bus.OpE    = 2'b00;
        bus.RD1E   = 32'd2;
        bus.RD2E   = 32'd2;
        tick();
        bus.StartE = 1'b0;
        bus.FlushE = 1'b0;
        #1;
        check_quiet("flush_idle_no_start");

        // Flush at iteration 10, then fresh MUL
        bus.StartE = 1'b1;
        bus.OpE    = 2'b00;
        bus.RD1E   = 32'd12345;
        bus.RD2E   = 32'd678;
        tick();
        bus.StartE = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        bus.FlushE = 1'b1;
        #1;
        check("flush_iter_stall", {63'd0, bus.StallMD}, 64'd1);
        tick();
        bus.FlushE = 1'b0;
        #1;
        check_quiet("flush_idle");
        wait_no_done("flush_no_done", 40);
        op_and_check("post_flush_mul", 2'b00, 32'd3, 32'd3, 32'd9, 33);

        // Reset at iteration 20
        bus.StartE = 1'b1;
        bus.OpE    = 2'b01;
        bus.RD1E   = 32'd1000;
        bus.RD2E   = 32'd3;
        tick();
        bus.StartE = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_quiet("mid_reset");
        wait_no_done("mid_reset_no_done", 40);

        // StartE held during MUL and in DONE is ignored
        bus.StartE = 1'b1;
        bus.OpE    = 2'b00;
        bus.RD1E   = 32'd1234;
        bus.RD2E   = 32'd5678;
        tick();
        bus.StartE = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        bus.StartE = 1'b1;
        bus.OpE    = 2'b01;
        bus.RD1E   = 32'd99;
        bus.RD2E   = 32'd3;
        #1;
        lat  = -1;
        done = 1'b0;
        ra   = '0;
        for (int c = 6; c <= 100 && !done; c++) begin
            if (bus.DoneMD) begin
                lat  = c;
                ra   = bus.ResultMD;
                done = 1'b1;
            end else begin
                tick();
            end
        end
        check("busy_start_result", {32'd0, ra}, 64'd7006652);
        check("busy_start_latency", 64'(lat), 64'd33);
        tick();
        bus.StartE = 1'b0;
        #1;
        check("done_start_ignored", {63'd0, bus.AluOwn}, 64'd0);
        tick();

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 2));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            op_and_check($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb),
                         (rop != 2'b00 && rb == 0) ? 1 : 33);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
